jstk_spi_responder: RTL
=======================

// Module: jstk_spi_responder
// PURPOSE
//  SPI mode-0 slave that emulates the PmodJSTK end of the 5-byte joystick transaction, for loopback and bench use.
//  Oversamples SS/SCLK/MOSI on the system clock and shifts in NBYTES command bytes, MSB first.
//  Shifts out NBYTES response bytes on MISO, taken from TX_DIN and captured at frame start.
//  Publishes the received frame on RX_DOUT with a one-cycle RX_VALID strobe.
// PARAMETERS
//  NBYTES       5   bytes per frame; data buses are 8*NBYTES wide
//  SYNC_STAGES  2   flip-flop stages on SS/SCLK/MOSI (minimum 2)
// PORTS
//  CLK        in   1         system clock; at least 8x SCLK
//  RST        in   1         reset, synchronous, active-high
//  SS         in   1         slave select, active low (async to CLK)
//  SCLK       in   1         SPI clock, idles low (async to CLK)
//  MOSI       in   1         master-out data
//  MISO       out  1         slave-out data; 0 while deselected
//  MISO_OE    out  1         1 while SS (synchronized) is low
//  TX_DIN     in   8*NBYTES  response frame, byte0 = [8*NBYTES-1 -: 8]
//  RX_DOUT    out  8*NBYTES  last complete command frame, byte0 in MSBs
//  RX_VALID   out  1         1-cycle pulse when RX_DOUT updates
//  BUSY       out  1         1 from SS fall until frame commit/abort
//  FRAME_ERR  out  1         sticky error flag (FRAME_CHECK_EN only)
// BEHAVIOUR
//  Reset (RST=1 on a CLK edge): all outputs 0, state IDLE, counters 0.
//   Sync registers reset to "SS asserted", so a frame already in progress at reset is ignored.
//   The next frame starts only after SS is seen high.
//  Sync: SS/SCLK/MOSI each pass through SYNC_STAGES flops.
//   Edges are detected on the last two stages (ss_fall, ss_rise, sck_rise, sck_fall).
//  FSM states:
//   IDLE  : MISO=0. On ss_fall: load tx_sr<=TX_DIN, bit/byte counters <=0, BUSY<=1, MISO<=TX_DIN MSB, go SHIFT.
//   SHIFT : on sck_rise: rx_sr <= {rx_sr, MOSI_sync}, bit_cnt++.
//           At bit_cnt 7->0 wrap: byte_cnt++; when byte_cnt reaches NBYTES, go FULL.
//           On sck_fall (not after the final bit): tx_sr shifts left, MISO <= new MSB.
//   FULL  : further SCLK edges are ignored; MISO=0.
//   Any state except IDLE, on ss_rise:
//     - if byte_cnt==NBYTES and bit_cnt==0: RX_DOUT<=rx_sr, RX_VALID=1 for exactly one CLK.
//     - otherwise the frame is discarded; RX_DOUT is held.
//     - BUSY<=0, go IDLE.
//  Latency: RX_VALID rises SYNC_STAGES+2 CLKs after the raw SS rise.
//  Master constraint: at least SYNC_STAGES+3 CLKs from SS fall to the first SCLK rise, so MISO bit7 is valid.
//  Simultaneous ss_rise with sck edge: ss_rise wins; the sck edge is dropped.
//  TX_DIN changes while BUSY have no effect on the current frame.
// CONFIGURATION
//  `define JSTK_FRAME_CHECK_EN:
//   FRAME_ERR set on ss_rise with a partial frame (bit_cnt!=0 or byte_cnt!=NBYTES) or on any sck_rise in FULL.
//   Cleared by RST only.
//  Without it: FRAME_ERR is tied 0 and partial frames are discarded silently.
// STRUCTURE
//  Package jstk_spi_pkg:
//   - FSM state localparams (IDLE/SHIFT/FULL);
//   - JSTK_NBYTES=5;
//   - byte-index helper constants shared with the master controller.
//  Sub-module jstk_spi_sync: SYNC_STAGES synchronizer plus rise/fall edge detector, instanced for SS and SCLK.
//   MOSI uses the sync chain only, no edge detector.
// TESTING
//  1 TX_DIN=40'hA5_3C_0F_F0_81, MOSI frame 40'hC1_00_00_00_00, SCLK=CLK/16
//    -> MISO bytes A5,3C,0F,F0,81; RX_DOUT=40'hC1_00_00_00_00; one RX_VALID pulse.
//  2 SS high after 2 bytes + 3 bits -> no RX_VALID, RX_DOUT unchanged, BUSY returns 0;
//    FRAME_ERR=1 with the macro defined, 0 without.
//  3 Two back-to-back frames (TX_DIN changed mid-frame-1 to 40'h1122334455)
//    -> frame1 returns the old TX_DIN, frame2 returns 11,22,33,44,55.
//  4 RST asserted mid-byte-3 while SS stays low, then released -> all outputs 0, no RX_VALID;
//    the next full SS cycle works normally.
//  5 Extra 8 SCLKs after 5 bytes -> MISO stays 0, RX_DOUT = first 5 bytes; FRAME_ERR=1 with the macro defined.
//  6 Run the full 5-byte transaction against the master controller
//    -> master DOUT equals TX_DIN and responder RX_DOUT equals master DIN.

Source files
------------

// File: rtl/jstk_spi_responder_pkg.sv
// jstk_spi_pkg
// Shared definitions for the PmodJSTK SPI responder and the master controller
// that talks to it.
//   JSTK_NBYTES    : bytes in one joystick transaction
//   jstkState_t    : responder FSM states
//   jstkByteIdx_t  : names for the byte positions inside a frame (byte0 first on the wire)
//   byteMsb()      : bit index of a byte's MSB inside an 8*nbytes frame bus
package jstk_spi_pkg;

  localparam int JSTK_NBYTES = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2
  } jstkState_t;

  typedef enum int {
    JSTK_XLO = 0,
    JSTK_XHI = 1,
    JSTK_YLO = 2,
    JSTK_YHI = 3,
    JSTK_BTN = 4
  } jstkByteIdx_t;

  // Byte 0 sits in the top bits of a frame bus, so byte idx starts at
  // bit 8*(nbytes-idx)-1 and runs down 8 bits.
  function automatic int byteMsb(input int idx, input int nbytes);
    return 8 * (nbytes - idx) - 1;
  endfunction

endpackage

// File: rtl/jstk_spi_responder_if.sv
// jstk_spi_responder_if
// Bundles the SPI pins and the parallel frame buses of the joystick responder.
//   SS, SCLK, MOSI      : SPI inputs from the master (asynchronous to CLK)
//   MISO, MISO_OE       : SPI output and its enable
//   TX_DIN / RX_DOUT    : response frame in, received command frame out
//   RX_VALID, BUSY      : frame-commit strobe and transaction-in-progress flag
//   FRAME_ERR           : sticky framing error (0 unless the check is built in)
// Modports: slave = the responder, master = whoever drives the SPI lines.
interface jstk_spi_responder_if
  import jstk_spi_pkg::*;
#(
  parameter int NBYTES = JSTK_NBYTES
);

  logic                  SS;
  logic                  SCLK;
  logic                  MOSI;
  logic                  MISO;
  logic                  MISO_OE;
  logic [8*NBYTES-1:0]   TX_DIN;
  logic [8*NBYTES-1:0]   RX_DOUT;
  logic                  RX_VALID;
  logic                  BUSY;
  logic                  FRAME_ERR;

  modport master (
    output SS, SCLK, MOSI, TX_DIN,
    input  MISO, MISO_OE, RX_DOUT, RX_VALID, BUSY, FRAME_ERR
  );

  modport slave (
    input  SS, SCLK, MOSI, TX_DIN,
    output MISO, MISO_OE, RX_DOUT, RX_VALID, BUSY, FRAME_ERR
  );

endinterface

// File: rtl/jstk_spi_responder_sync.sv
// jstk_spi_sync
// Multi-flop synchronizer for one asynchronous input plus registered
// rise/fall detection on its synchronized level.
//   CLK, RST : system clock, synchronous active-high reset
//   din      : asynchronous input
//   rise     : one-CLK pulse after a synchronized 0->1 transition
//   fall     : one-CLK pulse after a synchronized 1->0 transition
// RESET_VAL sets the level the chain assumes at reset, so no edge is
// reported for an input that already sits at that level.
module jstk_spi_sync
  import jstk_spi_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the input through the synchronizer, keep one more copy of the
  // settled level, and register the edge pulses so the FSM sees clean
  // single-cycle strobes. The total delay here is matched by the MOSI chain
  // in the top level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~prev;
      fall  <= ~chain[STAGES-1] & prev;
    end
  end

endmodule

// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder
// SPI mode-0 slave emulating the PmodJSTK side of the joystick transaction.
// SS/SCLK/MOSI are oversampled on CLK; NBYTES command bytes are shifted in
// MSB first while the response frame captured from TX_DIN at SS fall is
// shifted out on MISO. A complete frame is published on RX_DOUT with a
// one-cycle RX_VALID strobe when SS rises.
//   CLK, RST : system clock (>= 8x SCLK), synchronous active-high reset
//   bus      : jstk_spi_responder_if slave modport (SPI pins + frame buses)
// Optional build macro JSTK_FRAME_CHECK_EN: enables the sticky FRAME_ERR flag
// for partial frames and for SCLK activity after the last byte. Without it
// FRAME_ERR is tied low and partial frames are dropped silently.
module jstk_spi_responder
  import jstk_spi_pkg::*;
#(
  parameter int NBYTES      = JSTK_NBYTES,
  parameter int SYNC_STAGES = 2
) (
  input logic               CLK,
  input logic               RST,
  jstk_spi_responder_if.slave bus
);

  localparam int             W         = 8 * NBYTES;
  localparam int             CW        = $clog2(NBYTES + 1);
  localparam int             TOP_BIT   = byteMsb(int'(JSTK_XLO), NBYTES);
  localparam logic [CW-1:0]  LAST_BYTE = CW'(NBYTES);

  logic ssRise, ssFall, sckRise, sckFall;
  logic [SYNC_STAGES:0] mosiChain;
  logic mosiSync;

  jstkState_t state, nextState;
  logic [W-1:0]  txSr, txSrNxt, rxSr, rxSrNxt, rxDout, rxDoutNxt;
  logic [2:0]    bitCnt, bitCntNxt;
  logic [CW-1:0] byteCnt, byteCntNxt;
  logic          busy, busyNxt, rxValid, rxValidNxt;
`ifdef JSTK_FRAME_CHECK_EN
  logic          errFlag, errNxt;
`endif

  // SS resets to "asserted" so a transaction already running at reset is
  // ignored until SS has been seen high again.
  jstk_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) ssSync (
    .CLK(CLK), .RST(RST), .din(bus.SS), .rise(ssRise), .fall(ssFall)
  );

  jstk_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) sckSync (
    .CLK(CLK), .RST(RST), .din(bus.SCLK), .rise(sckRise), .fall(sckFall)
  );

  // MOSI needs no edge detection, but its chain is one flop longer than
  // SYNC_STAGES so the bit we sample lines up with the registered SCLK
  // edge pulse coming out of the synchronizer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mosiChain <= '0;
    end else begin
      mosiChain <= {mosiChain[SYNC_STAGES-1:0], bus.MOSI};
    end
  end

  assign mosiSync = mosiChain[SYNC_STAGES];

  // State and datapath registers; all next values come from the
  // combinational block below.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      txSr    <= '0;
      rxSr    <= '0;
      rxDout  <= '0;
      bitCnt  <= '0;
      byteCnt <= '0;
      busy    <= 1'b0;
      rxValid <= 1'b0;
`ifdef JSTK_FRAME_CHECK_EN
      errFlag <= 1'b0;
`endif
    end else begin
      state   <= nextState;
      txSr    <= txSrNxt;
      rxSr    <= rxSrNxt;
      rxDout  <= rxDoutNxt;
      bitCnt  <= bitCntNxt;
      byteCnt <= byteCntNxt;
      busy    <= busyNxt;
      rxValid <= rxValidNxt;
`ifdef JSTK_FRAME_CHECK_EN
      errFlag <= errNxt;
`endif
    end
  end

  // Frame sequencing. SS rising ends any active frame and takes priority
  // over a coincident SCLK edge. A frame commits only when exactly NBYTES
  // whole bytes were clocked; FULL keeps the counters frozen so extra SCLKs
  // after the last byte neither corrupt the frame nor drive MISO.
  always_comb begin
    nextState  = state;
    txSrNxt    = txSr;
    rxSrNxt    = rxSr;
    rxDoutNxt  = rxDout;
    bitCntNxt  = bitCnt;
    byteCntNxt = byteCnt;
    busyNxt    = busy;
    rxValidNxt = 1'b0;
`ifdef JSTK_FRAME_CHECK_EN
    errNxt     = errFlag;
`endif
    if (state != ST_IDLE && ssRise) begin
      if (byteCnt == LAST_BYTE && bitCnt == 3'd0) begin
        rxDoutNxt  = rxSr;
        rxValidNxt = 1'b1;
      end
`ifdef JSTK_FRAME_CHECK_EN
      else begin
        errNxt = 1'b1;
      end
`endif
      busyNxt   = 1'b0;
      nextState = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ssFall) begin
            txSrNxt    = bus.TX_DIN;
            bitCntNxt  = '0;
            byteCntNxt = '0;
            busyNxt    = 1'b1;
            nextState  = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sckRise) begin
            rxSrNxt   = {rxSr[W-2:0], mosiSync};
            bitCntNxt = bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              byteCntNxt = byteCnt + CW'(1);
              if (byteCntNxt == LAST_BYTE) begin
                nextState = ST_FULL;
              end
            end
          end else if (sckFall) begin
            txSrNxt = {txSr[W-2:0], 1'b0};
          end
        end
        ST_FULL: begin
`ifdef JSTK_FRAME_CHECK_EN
          if (sckRise) begin
            errNxt = 1'b1;
          end
`endif
        end
        default: begin
          nextState = ST_IDLE;
        end
      endcase
    end
  end

  // MISO is the head of the response shifter while shifting and low
  // everywhere else, including FULL and deselected.
  assign bus.MISO     = (state == ST_SHIFT) ? txSr[TOP_BIT] : 1'b0;
  assign bus.MISO_OE  = busy;
  assign bus.BUSY     = busy;
  assign bus.RX_DOUT  = rxDout;
  assign bus.RX_VALID = rxValid;
`ifdef JSTK_FRAME_CHECK_EN
  assign bus.FRAME_ERR = errFlag;
`else
  assign bus.FRAME_ERR = 1'b0;
`endif

endmodule
